div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter A_WIDTH, default 25, dividend and quotient width in bits (>= 2).
REQ-002 SHALL have parameter B_WIDTH, default 18, divisor and remainder width in bits (>= 2, <= A_WIDTH).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_i  input  1  operands on a_i/b_i are valid.
REQ-006 SHALL have port a_i  input  A_WIDTH  signed dividend.
REQ-007 SHALL have port b_i  input  B_WIDTH  signed divisor.
REQ-008 SHALL have port ready_o  output  1  the block can accept new operands.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse: results valid.
REQ-010 SHALL have port quot_o  output  A_WIDTH  signed quotient.
REQ-011 SHALL have port rem_o  output  B_WIDTH  signed remainder.
REQ-012 SHALL have port dz_o  output  1  divide-by-zero flag, qualified by valid_o.
REQ-013 SHALL have port ovf_o  output  1  quotient-overflow flag, qualified by valid_o.

Function
REQ-014 SHALL use only LUT/carry logic: iterative restoring division, one quotient bit per cycle, no multipliers or DSP inference.
REQ-015 SHALL implement FSM states IDLE, CALC, FIX; ready_o = 1 only in IDLE.
REQ-016 SHALL accept operands on the edge where valid_i && ready_o; it SHALL register |a_i|, |b_i| and both signs, clear the iteration counter, and go IDLE->CALC.
REQ-017 SHALL ignore valid_i while not in IDLE; a_i/b_i need not be held after acceptance.
REQ-018 SHALL perform exactly A_WIDTH iterations in CALC, then go CALC->FIX; the counter SHALL be $clog2(A_WIDTH+1) bits wide.
REQ-019 SHALL apply sign correction in FIX, register all outputs, pulse valid_o for one cycle, and go FIX->IDLE.
REQ-020 SHALL have a fixed latency: if the acceptance edge is edge 0, valid_o is high for exactly the cycle after edge A_WIDTH+1. ready_o rises on the same edge.
REQ-021 SHALL truncate toward zero: quotient negative iff operand signs differ; remainder takes the sign of the dividend; a == q*b + r and |r| < |b|.
REQ-022 SHALL handle b == 0 with the same latency, giving quot_o = all ones, rem_o = 0, dz_o = 1, ovf_o = 0.
REQ-023 SHALL handle a == -2^(A_WIDTH-1) with b == -1 by giving quot_o = -2^(A_WIDTH-1) (wrapped), rem_o = 0, ovf_o = 1, dz_o = 0.
REQ-024 SHALL handle the most-negative dividend/divisor magnitudes through an internal datapath one bit wider than the operands, without loss.
REQ-025 SHALL hold quot_o, rem_o, dz_o and ovf_o stable from the valid_o pulse until the next FIX.
REQ-026 SHALL allow back-to-back operation: a new valid_i accepted on the cycle ready_o rises.

Reset
REQ-027 SHALL, with rst_i high at a clock edge, enter IDLE and clear to 0 the counter, valid_o, quot_o, rem_o, dz_o and ovf_o; ready_o SHALL be 1 after the edge.
REQ-028 SHALL, when rst_i is asserted mid-CALC or mid-FIX, abort the operation with no valid_o pulse for it; rst_i SHALL take priority over valid_i.

Configuration
REQ-029 SHALL support macro DIV_SEQ_REM_EN: when defined, rem_o carries the remainder per REQ-021..023.
REQ-030 SHALL, without DIV_SEQ_REM_EN, tie rem_o to 0 and remove remainder sign-correction logic; quotient, flags and latency SHALL be unchanged.

Verification
REQ-031 SHALL cover a=100, b=7 -> quot_o=14, rem_o=2, dz_o=0, ovf_o=0, valid_o exactly 26 cycles after acceptance (defaults).
REQ-032 SHALL cover a=-100, b=7 -> quot_o=-14, rem_o=-2; a=100, b=-7 -> quot_o=-14, rem_o=2.
REQ-033 SHALL cover a=12345, b=0 -> quot_o=all ones, rem_o=0, dz_o=1, same latency.
REQ-034 SHALL cover a=-16777216, b=-1 -> quot_o=-16777216, ovf_o=1; a=-16777216, b=-131072 -> quot_o=128, rem_o=0.
REQ-035 SHALL cover rst_i pulsed 10 cycles after acceptance -> no valid_o, ready_o=1 next cycle; a new op (50/5) then returns quot_o=10.
REQ-036 SHALL cover valid_i held high continuously -> ops accepted every 27 cycles, each result correct, valid_i during CALC ignored.

Source files
------------

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring signed divider, one quotient bit per cycle
// Macro DIV_SEQ_REM_EN enables the signed remainder on rem_o; otherwise rem_o is tied to 0.
module div_seq #(
  parameter int A_WIDTH = 25,
  parameter int B_WIDTH = 18
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [A_WIDTH-1:0] quot_o,
  output logic [B_WIDTH-1:0] rem_o,
  output logic               dz_o,
  output logic               ovf_o
);

  localparam int CW = $clog2(A_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [A_WIDTH-1:0] qsh_q;
  logic [B_WIDTH:0]   prem_q;
  logic [B_WIDTH:0]   bmag_q;
  logic               a_neg_q, b_neg_q, dz_pend_q, ovf_pend_q;

  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH:0]   b_ext, b_mag;
  logic [B_WIDTH+1:0] trial;
  logic               q_bit;
  logic [B_WIDTH:0]   prem_nxt;
  logic               last_iter;

  // |a| fits A_WIDTH bits unsigned even for the most negative dividend
  assign a_mag = a_i[A_WIDTH-1] ? -a_i : a_i;
  assign b_ext = {b_i[B_WIDTH-1], b_i};
  assign b_mag = b_ext[B_WIDTH] ? -b_ext : b_ext;

  // dividend bits shift out of qsh_q's top while quotient bits shift in at the bottom
  assign trial    = {prem_q, qsh_q[A_WIDTH-1]};
  assign q_bit    = trial >= {1'b0, bmag_q};
  assign prem_nxt = q_bit ? (trial[B_WIDTH:0] - bmag_q) : trial[B_WIDTH:0];

  assign last_iter = (cnt_q == CW'(A_WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = CALC;
      CALC:    if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      valid_o <= 1'b0;
      quot_o  <= '0;
      dz_o    <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            cnt_q      <= '0;
            qsh_q      <= a_mag;
            prem_q     <= '0;
            bmag_q     <= b_mag;
            a_neg_q    <= a_i[A_WIDTH-1];
            b_neg_q    <= b_i[B_WIDTH-1];
            dz_pend_q  <= (b_i == '0);
            ovf_pend_q <= (a_i == {1'b1, {(A_WIDTH-1){1'b0}}}) && (&b_i);
          end
        end
        CALC: begin
          cnt_q  <= cnt_q + 1'b1;
          prem_q <= prem_nxt;
          qsh_q  <= {qsh_q[A_WIDTH-2:0], q_bit};
        end
        FIX: begin
          valid_o <= 1'b1;
          dz_o    <= dz_pend_q;
          ovf_o   <= ovf_pend_q;
          // the overflow case has equal signs, so its unnegated magnitude wraps to -2^(A_WIDTH-1)
          if (dz_pend_q)              quot_o <= '1;
          else if (a_neg_q ^ b_neg_q) quot_o <= -qsh_q;
          else                        quot_o <= qsh_q;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_SEQ_REM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_o <= '0;
    end else if (state_q == FIX) begin
      if (dz_pend_q)    rem_o <= '0;
      else if (a_neg_q) rem_o <= -prem_q[B_WIDTH-1:0];
      else              rem_o <= prem_q[B_WIDTH-1:0];
    end
  end
`else
  assign rem_o = '0;
`endif

endmodule
